// File: rtl/keystream_gen_pkg.sv
// Shared types for the AES-128 counter-mode keystream path: the 128-bit byte table,
// the keystream FSM states and the default counter width.
package aes_model_pack;

  typedef logic [15:0][7:0] byte_table;

  localparam int KS_CTR_WIDTH_DEFAULT = 32;

  // ERR only exists when counter wrap detection is built in
  typedef enum logic [2:0] {
    IDLE,
    LOAD_KEY,
    LOAD_SYNC,
    ENCRYPT,
    WAIT
`ifdef KEYSTREAM_GEN_WRAP_ERR_EN
    , ERR
`endif
  } ks_state_t;

  // Mask selecting the low 'width' bits of a counter block
  function automatic byte_table ctr_mask(input int width);
    logic [127:0] m;
    if (width >= 128)
      m = '1;
    else
      m = (128'(1) << width) - 128'(1);
    return m;
  endfunction

endpackage

// File: rtl/keystream_gen_if.sv
// Avalon-ST style stream carrying one 128-bit byte table per beat, with sop/eop framing.
interface avalon_st_if;

  aes_model_pack::byte_table data;
  logic                      valid;
  logic                      rdy;
  logic                      sop;
  logic                      eop;

  modport master (output data, valid, sop, eop, input rdy);
  modport slave  (input data, valid, sop, eop, output rdy);

endinterface

// File: rtl/keystream_gen_ctr_block_reg.sv
// Counter block register: loads a full 128-bit block, increments only the low
// CTR_WIDTH bits, and flags when the next increment would carry out of that field.
module ctr_block_reg
  import aes_model_pack::*;
#(
  parameter int CTR_WIDTH = KS_CTR_WIDTH_DEFAULT
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      load,
  input  byte_table load_data,
  input  logic      incr,
  output byte_table block,
  output logic      carry
);

  localparam byte_table CTR_MASK = ctr_mask(CTR_WIDTH);

  byte_table incremented;

  // Upper bits are held; the masked low field wraps on its own
  always_comb begin
    incremented = (block & ~CTR_MASK) | ((block + 128'(1)) & CTR_MASK);
  end

  assign carry = ((block & CTR_MASK) == CTR_MASK);

  always_ff @(posedge clk) begin
    if (rst)
      block <= '0;
    else if (load)
      block <= load_data;
    else if (incr)
      block <= incremented;
  end

endmodule

// File: rtl/keystream_gen.sv
// Counter-mode keystream source: loads key/sync over a two-beat stream, drives the AES core
// per counter block. Optional macro KEYSTREAM_GEN_WRAP_ERR_EN traps counter wrap in ERR.
module keystream_gen
  import aes_model_pack::*;
#(
  parameter int CTR_WIDTH = KS_CTR_WIDTH_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  avalon_st_if.slave key_sync_st,
  input  logic       key_and_sync_req,
  input  logic       new_sync_req,
  output logic       key_and_sync_vld,
  output logic       cipher_block_vld,
  output byte_table  cipher_block,
  output logic       aes_start,
  output byte_table  aes_key,
  output byte_table  aes_block,
  input  logic       aes_done,
  input  byte_table  aes_result
`ifdef KEYSTREAM_GEN_WRAP_ERR_EN
  ,
  output logic       ctr_wrap_err
`endif
);

  ks_state_t state;
  ks_state_t next_state;

  logic beat_accept;
  logic ctr_carry;

  logic rdy_d;
  logic ks_vld_d;
  logic start_d;
  logic cipher_vld_d;
  logic key_load;
  logic ctr_load;
  logic ctr_incr;
  logic cipher_load;
`ifdef KEYSTREAM_GEN_WRAP_ERR_EN
  logic wrap_set;
`else
  logic unused_ctr_carry;
  assign unused_ctr_carry = ctr_carry;
`endif

  assign beat_accept = key_sync_st.valid & key_sync_st.rdy;

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= next_state;
  end

  // A beat carrying eop in LOAD_SYNC wins over sop, so a single-beat packet loads the counter
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (key_and_sync_req) next_state = LOAD_KEY;
      LOAD_KEY:  if (beat_accept && key_sync_st.sop) next_state = LOAD_SYNC;
      LOAD_SYNC: if (beat_accept && key_sync_st.eop) next_state = ENCRYPT;
      ENCRYPT:   if (aes_done) next_state = WAIT;
      WAIT: begin
        if (key_and_sync_req)
          next_state = LOAD_KEY;
        else if (new_sync_req) begin
`ifdef KEYSTREAM_GEN_WRAP_ERR_EN
          next_state = ctr_carry ? ERR : ENCRYPT;
`else
          next_state = ENCRYPT;
`endif
        end
      end
`ifdef KEYSTREAM_GEN_WRAP_ERR_EN
      ERR:       next_state = ERR;
`endif
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    rdy_d        = (next_state == LOAD_KEY) || (next_state == LOAD_SYNC);
    ks_vld_d     = 1'b0;
    start_d      = 1'b0;
    cipher_vld_d = 1'b0;
    key_load     = 1'b0;
    ctr_load     = 1'b0;
    ctr_incr     = 1'b0;
    cipher_load  = 1'b0;
`ifdef KEYSTREAM_GEN_WRAP_ERR_EN
    wrap_set     = 1'b0;
`endif
    case (state)
      LOAD_KEY: key_load = beat_accept && key_sync_st.sop;
      LOAD_SYNC: begin
        if (beat_accept && key_sync_st.eop) begin
          ctr_load = 1'b1;
          ks_vld_d = 1'b1;
          start_d  = 1'b1;
        end else if (beat_accept && key_sync_st.sop) begin
          key_load = 1'b1;
        end
      end
      ENCRYPT: begin
        cipher_load  = aes_done;
        cipher_vld_d = aes_done;
      end
      WAIT: begin
        if (!key_and_sync_req && new_sync_req) begin
`ifdef KEYSTREAM_GEN_WRAP_ERR_EN
          wrap_set = ctr_carry;
          ctr_incr = !ctr_carry;
          start_d  = !ctr_carry;
`else
          ctr_incr = 1'b1;
          start_d  = 1'b1;
`endif
        end
      end
      default: ;
    endcase
  end

  // All handshake and data outputs are registered copies of the decoded values above
  always_ff @(posedge clk) begin
    if (rst) begin
      key_sync_st.rdy  <= 1'b0;
      key_and_sync_vld <= 1'b0;
      aes_start        <= 1'b0;
      cipher_block_vld <= 1'b0;
      cipher_block     <= '0;
      aes_key          <= '0;
`ifdef KEYSTREAM_GEN_WRAP_ERR_EN
      ctr_wrap_err     <= 1'b0;
`endif
    end else begin
      key_sync_st.rdy  <= rdy_d;
      key_and_sync_vld <= ks_vld_d;
      aes_start        <= start_d;
      cipher_block_vld <= cipher_vld_d;
      if (cipher_load)
        cipher_block <= aes_result;
      if (key_load)
        aes_key <= key_sync_st.data;
`ifdef KEYSTREAM_GEN_WRAP_ERR_EN
      if (wrap_set)
        ctr_wrap_err <= 1'b1;
`endif
    end
  end

  ctr_block_reg #(
    .CTR_WIDTH (CTR_WIDTH)
  ) u_ctr_block_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (ctr_load),
    .load_data (key_sync_st.data),
    .incr      (ctr_incr),
    .block     (aes_block),
    .carry     (ctr_carry)
  );

endmodule

// File: tb/tb_keystream_gen.sv
// Scoreboard bench for keystream_gen: stimulus pushes expected AES starts and cipher
// blocks; a negedge monitor pops and compares whenever the DUT pulses an output.
module tb_keystream_gen;
  import aes_model_pack::*;

  typedef struct packed {
    byte_table blk;
    byte_table key;
  } start_exp_t;

  localparam byte_table KEY0    = 128'h000102030405060708090A0B0C0D0E0F;
  localparam byte_table SYNC0   = 128'hF0E0D0C0B0A0908070605040FFFFFFFE;
  localparam byte_table SYNC0P1 = 128'hF0E0D0C0B0A0908070605040FFFFFFFF;
  localparam byte_table SYNC0P2 = 128'hF0E0D0C0B0A090807060504000000000;
  localparam byte_table KEYA    = 128'h1111111111111111AAAAAAAAAAAAAAAA;
  localparam byte_table KEYB    = 128'h22222222222222225555555555555555;
  localparam byte_table KEYC    = 128'h3C3C3C3C3C3C3C3CC3C3C3C3C3C3C3C3;
  localparam byte_table JUNK    = 128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF;
  localparam byte_table SYNC1   = 128'h123456789ABCDEF00F1E2D3C00000010;
  localparam byte_table SYNC2   = 128'h0102030405060708090A0B0C0D0E0F10;
  localparam byte_table RES0    = {16{8'hAA}};
  localparam byte_table RES1    = {16{8'hBB}};
  localparam byte_table RES2    = {16{8'hCC}};
  localparam byte_table RES3    = {16{8'h5A}};

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  logic      key_and_sync_req = 1'b0;
  logic      new_sync_req = 1'b0;
  logic      key_and_sync_vld;
  logic      cipher_block_vld;
  byte_table cipher_block;
  logic      aes_start;
  byte_table aes_key;
  byte_table aes_block;
  logic      aes_done = 1'b0;
  byte_table aes_result = '0;
`ifdef KEYSTREAM_GEN_WRAP_ERR_EN
  logic      ctr_wrap_err;
`endif

  int checks = 0;
  int errors = 0;
  int ks_pending = 0;
  start_exp_t start_q[$];
  byte_table  cipher_q[$];

  avalon_st_if ks ();

  always #5 clk = ~clk;

  keystream_gen dut (
    .clk              (clk),
    .rst              (rst),
    .key_sync_st      (ks),
    .key_and_sync_req (key_and_sync_req),
    .new_sync_req     (new_sync_req),
    .key_and_sync_vld (key_and_sync_vld),
    .cipher_block_vld (cipher_block_vld),
    .cipher_block     (cipher_block),
    .aes_start        (aes_start),
    .aes_key          (aes_key),
    .aes_block        (aes_block),
    .aes_done         (aes_done),
    .aes_result       (aes_result)
`ifdef KEYSTREAM_GEN_WRAP_ERR_EN
    ,
    .ctr_wrap_err     (ctr_wrap_err)
`endif
  );

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends one stream beat once rdy is up; a missing rdy counts as a failed check
  task automatic applyStimulus(input byte_table data, input logic sop, input logic eop);
    int wait_cnt;
    wait_cnt = 0;
    while (!ks.rdy && wait_cnt < 20) begin
      stepCycles(1);
      wait_cnt++;
    end
    checkOutput("rdy_before_beat", 128'(ks.rdy), 128'(1));
    ks.data  = data;
    ks.sop   = sop;
    ks.eop   = eop;
    ks.valid = 1'b1;
    stepCycles(1);
    ks.valid = 1'b0;
    ks.sop   = 1'b0;
    ks.eop   = 1'b0;
  endtask

  task automatic pulseDone(input byte_table res);
    aes_result = res;
    aes_done   = 1'b1;
    cipher_q.push_back(res);
    stepCycles(1);
    aes_done = 1'b0;
    checkOutput("cipher_vld_timing", 128'(cipher_block_vld), 128'(1));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_rdy"}, 128'(ks.rdy), 128'(0));
    checkOutput({tag, "_ks_vld"}, 128'(key_and_sync_vld), 128'(0));
    checkOutput({tag, "_cipher_vld"}, 128'(cipher_block_vld), 128'(0));
    checkOutput({tag, "_aes_start"}, 128'(aes_start), 128'(0));
    checkOutput({tag, "_aes_key"}, aes_key, 128'(0));
    checkOutput({tag, "_aes_block"}, aes_block, 128'(0));
    checkOutput({tag, "_cipher_block"}, cipher_block, 128'(0));
    checkOutput({tag, "_state"}, 128'(dut.state), 128'(IDLE));
`ifdef KEYSTREAM_GEN_WRAP_ERR_EN
    checkOutput({tag, "_wrap_err"}, 128'(ctr_wrap_err), 128'(0));
`endif
  endtask

  // Monitor: every output pulse must match the oldest pending expectation
  always @(negedge clk) begin
    start_exp_t se;
    byte_table  ce;
    if (aes_start) begin
      if (start_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL aes_start_unexpected: got aes_start=1 block=%h, required no start", aes_block);
      end else begin
        se = start_q.pop_front();
        checkOutput("aes_block", aes_block, se.blk);
        checkOutput("aes_key", aes_key, se.key);
      end
    end
    if (cipher_block_vld) begin
      if (cipher_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL cipher_vld_unexpected: got cipher_block_vld=1, required 0");
      end else begin
        ce = cipher_q.pop_front();
        checkOutput("cipher_block", cipher_block, ce);
      end
    end
    if (key_and_sync_vld) begin
      checks++;
      if (ks_pending == 0) begin
        errors++;
        $display("[TB] FAIL ks_vld_unexpected: got key_and_sync_vld=1, required 0");
      end else begin
        ks_pending--;
      end
      checkOutput("ks_vld_with_start", 128'(aes_start), 128'(1));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, required end before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    ks.data  = '0;
    ks.valid = 1'b0;
    ks.sop   = 1'b0;
    ks.eop   = 1'b0;

    stepCycles(3);
    checkResetValues("reset");
    rst = 1'b0;
    stepCycles(1);

    // First key/sync load and encryption
    key_and_sync_req = 1'b1;
    stepCycles(1);
    checkOutput("rdy_rise", 128'(ks.rdy), 128'(1));
    start_q.push_back('{blk: SYNC0, key: KEY0});
    ks_pending++;
    applyStimulus(KEY0, 1'b1, 1'b0);
    applyStimulus(SYNC0, 1'b0, 1'b1);
    checkOutput("ks_vld_timing", 128'(key_and_sync_vld), 128'(1));
    checkOutput("start_timing", 128'(aes_start), 128'(1));
    checkOutput("rdy_fall", 128'(ks.rdy), 128'(0));
    stepCycles(1);
    key_and_sync_req = 1'b0;
    stepCycles(2);
    pulseDone(RES0);
    stepCycles(1);

    // First increment: low word reaches all ones
    start_q.push_back('{blk: SYNC0P1, key: KEY0});
    new_sync_req = 1'b1;
    stepCycles(1);
    new_sync_req = 1'b0;
    checkOutput("start_after_sync", 128'(aes_start), 128'(1));
    stepCycles(2);
    pulseDone(RES1);
    stepCycles(1);

`ifdef KEYSTREAM_GEN_WRAP_ERR_EN
    new_sync_req = 1'b1;
    stepCycles(1);
    new_sync_req = 1'b0;
    checkOutput("wrap_no_start", 128'(aes_start), 128'(0));
    checkOutput("wrap_err_set", 128'(ctr_wrap_err), 128'(1));
    checkOutput("wrap_state_err", 128'(dut.state), 128'(ERR));
    key_and_sync_req = 1'b1;
    stepCycles(3);
    key_and_sync_req = 1'b0;
    checkOutput("wrap_err_sticky", 128'(ctr_wrap_err), 128'(1));
    checkOutput("err_rdy_low", 128'(ks.rdy), 128'(0));
    rst = 1'b1;
    stepCycles(2);
    rst = 1'b0;
    checkOutput("wrap_err_cleared", 128'(ctr_wrap_err), 128'(0));
    stepCycles(1);
`else
    start_q.push_back('{blk: SYNC0P2, key: KEY0});
    new_sync_req = 1'b1;
    stepCycles(1);
    new_sync_req = 1'b0;
    checkOutput("start_after_wrap", 128'(aes_start), 128'(1));
    stepCycles(2);
    pulseDone(RES2);
    stepCycles(1);
`endif

    // Stray non-sop beat, then key A replaced by key B
    key_and_sync_req = 1'b1;
    stepCycles(1);
    applyStimulus(JUNK, 1'b0, 1'b0);
    checkOutput("junk_state", 128'(dut.state), 128'(LOAD_KEY));
    checkOutput("junk_rdy", 128'(ks.rdy), 128'(1));
    start_q.push_back('{blk: SYNC1, key: KEYB});
    ks_pending++;
    applyStimulus(KEYA, 1'b1, 1'b0);
    applyStimulus(KEYB, 1'b1, 1'b0);
    checkOutput("resop_state", 128'(dut.state), 128'(LOAD_SYNC));
    applyStimulus(SYNC1, 1'b0, 1'b1);
    checkOutput("key_replaced", aes_key, KEYB);
    stepCycles(1);
    key_and_sync_req = 1'b0;
    stepCycles(1);
    pulseDone(RES3);
    stepCycles(1);

    // Key request beats new-sync request in WAIT
    key_and_sync_req = 1'b1;
    new_sync_req     = 1'b1;
    stepCycles(1);
    new_sync_req = 1'b0;
    checkOutput("prio_rdy", 128'(ks.rdy), 128'(1));
    checkOutput("prio_state", 128'(dut.state), 128'(LOAD_KEY));
    checkOutput("prio_no_start", 128'(aes_start), 128'(0));
    start_q.push_back('{blk: SYNC2, key: KEYC});
    ks_pending++;
    applyStimulus(KEYC, 1'b1, 1'b0);
    applyStimulus(SYNC2, 1'b0, 1'b1);
    key_and_sync_req = 1'b0;

    // Reset while the AES core is busy; its result must be dropped
    stepCycles(1);
    rst = 1'b1;
    stepCycles(1);
    aes_result = RES0;
    aes_done   = 1'b1;
    stepCycles(1);
    aes_done = 1'b0;
    stepCycles(1);
    rst = 1'b0;
    stepCycles(1);
    checkResetValues("midrst");
    aes_done = 1'b1;
    stepCycles(1);
    aes_done = 1'b0;
    stepCycles(3);
    checkOutput("idle_done_ignored", 128'(dut.state), 128'(IDLE));

    checkOutput("start_q_empty", 128'(start_q.size()), 128'(0));
    checkOutput("cipher_q_empty", 128'(cipher_q.size()), 128'(0));
    checkOutput("ks_pending_zero", 128'(ks_pending), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
